// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives one column low per slot, debounces a single key and
// emits one key_valid pulse per press; release is debounced before scanning resumes.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_CNT);

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_ACCEPT,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_row_s;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_col;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_row_cap;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  state_t        w_state_nxt;
  logic [1:0]    w_col_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_row_cap_nxt;
  logic [3:0]    w_key_code_nxt;
  logic          w_key_valid_nxt;
  logic          w_key_held_nxt;

  logic          w_sample;
  logic [3:0]    w_low;
  logic          w_valid;
  logic [1:0]    w_row_idx;
  logic          w_cap_low;
  logic [CW-1:0] w_cnt_inc;

  assign w_sample  = (r_slot == SLOT_LAST);
  assign w_low     = ~r_row_s;
  // Exactly one row low; none is a release, several is ghosting.
  assign w_valid   = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_cap_low = ~r_row_s[r_row_cap];
  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_row_idx = 2'd0;
    case (w_low)
      4'b0010: w_row_idx = 2'd1;
      4'b0100: w_row_idx = 2'd2;
      4'b1000: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b1111;
      r_row_s <= 4'b1111;
      r_slot  <= '0;
    end else begin
      r_sync1 <= row_in;
      r_row_s <= r_sync1;
      r_slot  <= w_sample ? '0 : r_slot + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SCAN;
      r_col       <= 2'd0;
      r_cnt       <= '0;
      r_row_cap   <= 2'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row_cap   <= w_row_cap_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
    end
  end

  // Key outputs are loaded on the edge into ACCEPT so they are visible during it.
  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_cnt_nxt       = r_cnt;
    w_row_cap_nxt   = r_row_cap;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
    case (r_state)
      S_SCAN: begin
        if (w_sample) begin
          if (w_valid) begin
            w_row_cap_nxt = w_row_idx;
            w_cnt_nxt     = CW'(1);
            if (DEBOUNCE_CNT == 1) begin
              w_state_nxt     = S_ACCEPT;
              w_key_code_nxt  = {w_row_idx, r_col};
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_DEBOUNCE;
            end
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (w_sample) begin
          if (w_valid && (w_row_idx == r_row_cap)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_DONE) begin
              w_state_nxt     = S_ACCEPT;
              w_key_code_nxt  = {r_row_cap, r_col};
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_col_nxt   = r_col + 2'd1;
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_ACCEPT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_sample && !w_cap_low) begin
          if (DEBOUNCE_CNT == 1) begin
            w_key_held_nxt = 1'b0;
            w_col_nxt      = r_col + 2'd1;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_SCAN;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (w_sample) begin
          if (!w_cap_low) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_DONE) begin
              w_key_held_nxt = 1'b0;
              w_col_nxt      = r_col + 2'd1;
              w_cnt_nxt      = '0;
              w_state_nxt    = S_SCAN;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
          end
        end
      end
      default: w_state_nxt = S_SCAN;
    endcase
  end

  assign col_out   = ~(4'b0001 << r_col);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the calculator's 4x4 matrix keypad.
- Drives one column low at a time, samples the rows, debounces a single key, and emits one registered key event per physical press.
- Replaces per-key edge detection with one controller that owns column drive, debounce and release tracking.
- Downstream calculator logic consumes key_code on the key_valid pulse.

Parameters:
- SCAN_DIV, 1000: clock cycles per column slot. Minimum 3, so the synchronizer latency fits inside the slot.
- DEBOUNCE_CNT, 3: consecutive matching slot samples needed to accept a press or a release. Minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row_in  in  4  keypad rows, active-low (pulled up), asynchronous to clk
- col_out  out  4  column drive, active-low one-hot
- key_code  out  4  code of the accepted key = row*4 + col; held until the next accepted key
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high from acceptance until the release is accepted

Behaviour:
- Reset (rst=1 at posedge clk):
  - col_out=4'b1110 (column 0); key_code=0, key_valid=0, key_held=0.
  - State=SCAN; slot counter, debounce counter and captured row/col all 0.
  - Synchronizer flops are set to 4'b1111.
  - Reset mid-operation aborts any press or release in progress; no key_valid is emitted.
- Synchronizer: row_in passes through 2 flops (row_s); all decisions use row_s.
- Slot timing:
  - Slot counter counts 0..SCAN_DIV-1 and wraps.
  - A "sample" occurs on the cycle the counter equals SCAN_DIV-1.
  - Column changes take effect on the cycle after a sample.
- Valid pattern: row_s has exactly one bit low. Zero bits low means released. Two or more low means ghosting and is treated as invalid.
- SCAN:
  - On each sample with a valid pattern: capture row index and current col, set count=1, go to DEBOUNCE. col_out stays frozen.
  - Otherwise advance the column: 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wraps).
  - If DEBOUNCE_CNT=1, go directly to ACCEPT instead of DEBOUNCE.
- DEBOUNCE (column frozen):
  - On each sample, if the pattern is valid and matches the captured row, count++.
  - Otherwise clear count, advance the column, return to SCAN.
  - When count reaches DEBOUNCE_CNT, go to ACCEPT.
- ACCEPT (one cycle):
  - key_code <= {row,col}; key_valid=1 for exactly this cycle; key_held <= 1; count=0; go to HOLD.
  - key_code and key_valid update in the same cycle.
- HOLD (column frozen, key_held=1):
  - On a sample with the captured row still low, stay.
  - On a sample with the captured row high, set count=1 and go to RELEASE, or go straight to the exit if DEBOUNCE_CNT=1.
  - Other rows going low in HOLD are ignored; no n-key rollover.
- RELEASE:
  - A sample with the captured row high increments count.
  - A sample with the captured row low clears count and returns to HOLD. No new key_valid is emitted.
  - When count reaches DEBOUNCE_CNT: key_held <= 0, advance the column, count=0, go to SCAN.
- Timing: minimum press-to-key_valid latency from a stable row_in is 2 sync cycles, plus the time to the sample, plus (DEBOUNCE_CNT-1)*SCAN_DIV, plus 1 cycle.
- Only one key_valid per press. Holding a key never auto-repeats.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset, rows 4'b1111:
  - All outputs 0; col_out=1110.
  - col_out steps 1110->1101->1011->0111->1110, each held exactly 4 cycles; key_valid never asserts.
- Hold row 2 low while col_out=1101 (key row2,col1) for 20 cycles:
  - Exactly one key_valid pulse; key_code=4'd9; key_held=1.
  - col_out stays 1101 through HOLD.
- Bounce: assert row 2 low for only 2 samples, then release:
  - No key_valid, key_code unchanged.
  - Scan resumes at the next column (1011).
- Ghosting: rows 4'b1010 (rows 0 and 2 low) on column 0 for 5 slots:
  - No key_valid, scanning continues.
- Release bounce after accepted key 9:
  - Pattern released, released, pressed, then 3 released samples: no second key_valid.
  - key_held falls only after the final third released sample; col_out then moves to 1011.
- rst pulse while key_held=1:
  - Next cycle: col_out=1110, key_held=0, key_code=0.
  - With the key still down, a fresh press is accepted only after a full debounce from SCAN.
